booth16_seq_mult: RTL and testbench

- Iterative signed multiplier controller built around a radix-16 Booth digit encoder.
- Accepts operand pairs over a valid/ready handshake.
- Precomputes the hard multiples 3A, 5A and 7A, then retires one 5-bit Booth window per cycle into an accumulator.
- Presents the 2*WIDTH-bit product on a valid/ready output. Sits between the operand source and the fixed-point result consumer.

---
 rtl/booth16_pkg.sv | 28 ++
 rtl/booth16_digit_enc.sv | 39 +++
 rtl/booth16_seq_mult.sv | 155 +++++++++++++++
 tb/tb_booth16_seq_mult.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth16_pkg.sv
// booth16_pkg
// Shared types for the radix-16 Booth sequential multiplier.
//   state_t          controller states (IDLE, PRECOMP, ITER, DONE)
//   booth_dig_t      encoded Booth digit: sign, one-hot odd multiple, one-hot shift
//   booth_digit_value signed value (-8..+8) of a 5-bit Booth window
package booth16_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRECOMP = 2'd1,
    ITER    = 2'd2,
    DONE    = 2'd3
  } state_t;

  // odd_sel bit k selects the odd multiple (2k+1)A; sh_sel bit k shifts it left by k.
  // A zero digit has both selects all-zero and neg=0.
  typedef struct packed {
    logic       neg;
    logic [3:0] odd_sel;
    logic [3:0] sh_sel;
  } booth_dig_t;

  // Window layout is {b[4i+3:4i], b[4i-1]}; the top bit carries weight -8.
  function automatic int booth_digit_value(input logic [4:0] w);
    return -8 * int'(w[4]) + 4 * int'(w[3]) + 2 * int'(w[2]) + int'(w[1]) + int'(w[0]);
  endfunction

endpackage

// File: rtl/booth16_digit_enc.sv
// booth16_digit_enc
// Purely combinational radix-16 Booth digit encoder.
//   win_i  5-bit Booth window {b[4i+3:4i], b[4i-1]}
//   dig_o  encoded digit: neg flag, one-hot odd multiple (1/3/5/7), one-hot shift (0..3)
module booth16_digit_enc
  import booth16_pkg::*;
(
  input  logic [4:0]  win_i,
  output booth_dig_t  dig_o
);

  logic [3:0] posPart;
  logic [3:0] mag;

  // The low four window bits always add a non-negative 0..8; the top bit subtracts 8.
  // When the top bit is set the digit is posPart-8, so its magnitude is 8-posPart and
  // it is negative only when posPart falls short of 8 (11111 is a plain zero).
  always_comb begin
    posPart = {1'b0, win_i[3:1]} + {3'b000, win_i[0]};
    dig_o   = '0;
    mag     = posPart;
    if (win_i[4]) begin
      mag       = 4'd8 - posPart;
      dig_o.neg = (posPart != 4'd8);
    end
    case (mag)
      4'd1:    begin dig_o.odd_sel = 4'b0001; dig_o.sh_sel = 4'b0001; end
      4'd2:    begin dig_o.odd_sel = 4'b0001; dig_o.sh_sel = 4'b0010; end
      4'd3:    begin dig_o.odd_sel = 4'b0010; dig_o.sh_sel = 4'b0001; end
      4'd4:    begin dig_o.odd_sel = 4'b0001; dig_o.sh_sel = 4'b0100; end
      4'd5:    begin dig_o.odd_sel = 4'b0100; dig_o.sh_sel = 4'b0001; end
      4'd6:    begin dig_o.odd_sel = 4'b0010; dig_o.sh_sel = 4'b0010; end
      4'd7:    begin dig_o.odd_sel = 4'b1000; dig_o.sh_sel = 4'b0001; end
      4'd8:    begin dig_o.odd_sel = 4'b0001; dig_o.sh_sel = 4'b1000; end
      default: begin dig_o.odd_sel = 4'b0000; dig_o.sh_sel = 4'b0000; end
    endcase
  end

endmodule

// File: rtl/booth16_seq_mult.sv
// booth16_seq_mult
// Iterative signed WIDTH x WIDTH multiplier retiring one radix-16 Booth digit per cycle.
//   iClk    clock, rising edge
//   iRst_n  asynchronous active-low reset
//   iValid  operand pair valid        oReady  block can accept a pair (IDLE only)
//   iA, iB  signed operands           oProd   signed 2*WIDTH product
//   oValid  product valid             iReady  consumer accepts the product
//   oBusy   high while precomputing or iterating
// Optional build macro BOOTH16_EARLY_TERM_EN: stop iterating as soon as every remaining
// multiplier digit is known to be zero.
module booth16_seq_mult
  import booth16_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iValid,
  output logic                 oReady,
  input  logic [WIDTH-1:0]     iA,
  input  logic [WIDTH-1:0]     iB,
  output logic                 oValid,
  input  logic                 iReady,
  output logic [2*WIDTH-1:0]   oProd,
  output logic                 oBusy
);

  localparam int NDIG = WIDTH / 4;
  localparam int PW   = 2 * WIDTH;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t          state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [PW-1:0]   mult1_q;
  logic [PW-1:0]   mult3_q;
  logic [PW-1:0]   mult5_q;
  logic [PW-1:0]   mult7_q;
  logic [PW-1:0]   accum_q;
  logic [PW-1:0]   accum_d;
  logic [IW-1:0]   digIdx_q;

  logic [PW-1:0]   aExt;
  logic [WIDTH:0]  bExt;
  logic [4:0]      window;
  logic            lastDig;
  booth_dig_t      dig;
  logic [PW-1:0]   oddMult;
  logic [PW-1:0]   shMult;
  logic [PW-1:0]   partProd;

  assign oReady  = (state_q == IDLE);
  assign aExt    = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  // The appended zero is the implicit b[-1] overlap bit of digit 0.
  assign bExt    = {b_q, 1'b0};
  assign window  = 5'(bExt >> {digIdx_q, 2'b00});
  assign lastDig = (digIdx_q == IW'(NDIG - 1));

`ifdef BOOTH16_EARLY_TERM_EN
  logic signed [WIDTH:0] bRest;
  logic                  earlyStop;
  // Everything from the current overlap bit upward all-zero or all-one means the
  // remaining Booth digits are all zero.
  assign bRest     = $signed(bExt) >>> {digIdx_q, 2'b00};
  assign earlyStop = (bRest == '0) || (&bRest);
`endif

  booth16_digit_enc uDigitEnc (
    .win_i (window),
    .dig_o (dig)
  );

  // Select the odd multiple, apply the small shift, move it to the digit's weight and
  // fold it into the accumulator. A zero digit selects nothing, so it adds exactly 0.
  always_comb begin
    oddMult  = ({PW{dig.odd_sel[0]}} & mult1_q) |
               ({PW{dig.odd_sel[1]}} & mult3_q) |
               ({PW{dig.odd_sel[2]}} & mult5_q) |
               ({PW{dig.odd_sel[3]}} & mult7_q);
    shMult   = ({PW{dig.sh_sel[0]}} & oddMult)        |
               ({PW{dig.sh_sel[1]}} & (oddMult << 1)) |
               ({PW{dig.sh_sel[2]}} & (oddMult << 2)) |
               ({PW{dig.sh_sel[3]}} & (oddMult << 3));
    partProd = shMult << {digIdx_q, 2'b00};
    accum_d  = dig.neg ? (accum_q - partProd) : (accum_q + partProd);
  end

  // Controller: accept, precompute hard multiples, one digit per cycle, then hold the
  // product until the consumer takes it. Reset aborts whatever is in flight.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mult1_q  <= '0;
      mult3_q  <= '0;
      mult5_q  <= '0;
      mult7_q  <= '0;
      accum_q  <= '0;
      digIdx_q <= '0;
      oValid   <= 1'b0;
      oBusy    <= 1'b0;
      oProd    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (iValid) begin
            a_q      <= iA;
            b_q      <= iB;
            accum_q  <= '0;
            digIdx_q <= '0;
            oBusy    <= 1'b1;
            state_q  <= PRECOMP;
          end
        end
        PRECOMP: begin
          mult1_q <= aExt;
          mult3_q <= aExt + (aExt << 1);
          mult5_q <= aExt + (aExt << 2);
          mult7_q <= (aExt << 3) - aExt;
          state_q <= ITER;
        end
        ITER: begin
`ifdef BOOTH16_EARLY_TERM_EN
          if (earlyStop) begin
            oProd   <= accum_q;
            oValid  <= 1'b1;
            oBusy   <= 1'b0;
            state_q <= DONE;
          end else
`endif
          begin
            accum_q <= accum_d;
            if (lastDig) begin
              oProd   <= accum_d;
              oValid  <= 1'b1;
              oBusy   <= 1'b0;
              state_q <= DONE;
            end else begin
              digIdx_q <= digIdx_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (iReady) begin
            oValid  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth16_seq_mult.sv
`timescale 1ns/1ps
module tb_booth16_seq_mult;
  import booth16_pkg::*;

  localparam int WIDTH = 8;
  localparam int NDIG  = WIDTH / 4;
  localparam int PW    = 2 * WIDTH;

  logic             iClk   = 1'b0;
  logic             iRst_n = 1'b0;
  logic             iValid = 1'b0;
  logic             iReady = 1'b0;
  logic [WIDTH-1:0] iA     = '0;
  logic [WIDTH-1:0] iB     = '0;
  logic             oReady;
  logic             oValid;
  logic             oBusy;
  logic [PW-1:0]    oProd;

  typedef struct {
    longint prod;
    int     lat;
  } exp_t;

  int       compared   = 0;
  int       mismatched = 0;
  exp_t     expQ[$];
  bit       inflight   = 1'b0;
  bit       seenValid  = 1'b0;
  bit       prevStall  = 1'b0;
  bit       checkEn    = 1'b0;
  logic [PW-1:0] prevProd = '0;
  int       sinceAcc   = 0;
  int       lastLat    = 0;
  int       readyMode  = 1;

  booth16_seq_mult #(.WIDTH(WIDTH)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iValid (iValid),
    .oReady (oReady),
    .iA     (iA),
    .iB     (iB),
    .oValid (oValid),
    .iReady (iReady),
    .oProd  (oProd),
    .oBusy  (oBusy)
  );

  // Free-running 100 MHz clock.
  always #5 iClk = ~iClk;

  // Hard stop so a wedged design still produces a verdict.
  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached, compared=%0d", compared);
    $fatal(1, "[TB] watchdog");
  end

  function automatic void check(input string name, input longint actual, input longint expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endfunction

  // Reference product: plain signed multiplication.
  function automatic longint modelProd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return longint'($signed(a)) * longint'($signed(b));
  endfunction

  // Edge (counting acceptance as edge 0) at which the consumer first sees the product:
  // one precompute cycle, the iteration cycles, then the sampling edge.
  function automatic int modelLat(input logic [WIDTH-1:0] b);
    int iters = NDIG;
`ifdef BOOTH16_EARLY_TERM_EN
    longint rest;
    for (int i = 0; i < NDIG; i++) begin
      rest = (longint'($signed(b)) * 2) >>> (4 * i);
      if (rest == 0 || rest == -1) begin
        iters = i + 1;
        break;
      end
    end
`endif
    return iters + 2;
  endfunction

  // Recombine the Booth digits of b; must reproduce b itself.
  function automatic longint digitSum(input logic [WIDTH-1:0] b);
    logic [WIDTH:0] be;
    longint         s;
    be = {b, 1'b0};
    s  = 0;
    for (int i = 0; i < NDIG; i++)
      s += longint'(booth_digit_value(be[4*i +: 5])) * (longint'(1) << (4 * i));
    return s;
  endfunction

  function automatic logic [WIDTH-1:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 8'h80;
      1:       return 8'h7F;
      2:       return 8'h00;
      3:       return 8'hFF;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  // Consumer: iReady held low, held high, or randomly stalling.
  initial forever begin
    @(posedge iClk);
    #1;
    case (readyMode)
      0:       iReady = 1'b0;
      1:       iReady = 1'b1;
      default: iReady = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Every-cycle compare against the scoreboard: handshake flags, latency, product value
  // and stability of a stalled product.
  always @(negedge iClk) begin
    if (checkEn && iRst_n) begin
      if (inflight) sinceAcc++;
      check("oReady", longint'(oReady), longint'(!inflight));
      check("oBusy", longint'(oBusy), longint'(inflight && !oValid));
      if (oValid) begin
        if (!inflight || expQ.size() == 0) begin
          check("oValidWhileIdle", longint'(oValid), 0);
        end else begin
          if (!seenValid) begin
            seenValid = 1'b1;
            lastLat   = sinceAcc + 1;
            check("latency", longint'(sinceAcc + 1), longint'(expQ[0].lat));
          end
          check("oProd", longint'($signed(oProd)), expQ[0].prod);
          if (prevStall) check("holdProd", longint'(oProd), longint'(prevProd));
          if (iReady) begin
            void'(expQ.pop_front());
            inflight = 1'b0;
          end
        end
      end else if (prevStall) begin
        check("holdValid", longint'(oValid), 1);
      end
      prevStall = oValid && !iReady;
      prevProd  = oProd;
      if (iValid && oReady) begin
        expQ.push_back('{modelProd(iA, iB), modelLat(iB)});
        inflight  = 1'b1;
        seenValid = 1'b0;
        sinceAcc  = -1;
      end
    end
  end

  // Offer one pair; optionally keep iValid high with junk data after acceptance.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input bit holdExtra);
    int t = 0;
    while (!oReady && t < 400) begin
      @(posedge iClk);
      #1;
      t++;
    end
    if (!oReady) begin
      check("readyTimeout", longint'(oReady), 1);
      return;
    end
    iA     = a;
    iB     = b;
    iValid = 1'b1;
    @(posedge iClk);
    #1;
    if (holdExtra) begin
      iA = WIDTH'($urandom);
      iB = WIDTH'($urandom);
      repeat (2) begin
        @(posedge iClk);
        #1;
      end
    end
    iValid = 1'b0;
    iA     = WIDTH'($urandom);
    iB     = WIDTH'($urandom);
  endtask

  // Wait for the product and compare against a hand-computed literal.
  task automatic checkOutput(input string name, input longint expected);
    int t = 0;
    do begin
      @(negedge iClk);
      t++;
    end while (!oValid && t < 400);
    if (!oValid) check({name, "_timeout"}, longint'(oValid), 1);
    else         check(name, longint'($signed(oProd)), expected);
    @(posedge iClk);
    #1;
  endtask

  task automatic setReady(input int m);
    @(negedge iClk);
    readyMode = m;
    @(posedge iClk);
    #2;
  endtask

  initial begin
    int t;
    $display("[TB] booth16_seq_mult bench, WIDTH=%0d", WIDTH);

    // Reset state.
    repeat (2) @(negedge iClk);
    check("rstValid", longint'(oValid), 0);
    check("rstBusy", longint'(oBusy), 0);
    check("rstProd", longint'(oProd), 0);
    @(posedge iClk);
    #1;
    iRst_n = 1'b1;
    #1;
    check("rstReady", longint'(oReady), 1);
    checkEn = 1'b1;

    // Pin the reference model with hand-worked values.
    check("digit01111", longint'(booth_digit_value(5'b01111)), 8);
    check("digit10000", longint'(booth_digit_value(5'b10000)), -8);
    check("digit11111", longint'(booth_digit_value(5'b11111)), 0);
    check("digit00110", longint'(booth_digit_value(5'b00110)), 3);
    check("modelMinMin", modelProd(8'h80, 8'h80), 16384);
    check("modelMaxMin", modelProd(8'h7F, 8'h80), -16256);
    for (int n = 0; n < 16; n++) begin
      logic [WIDTH-1:0] rb;
      rb = WIDTH'($urandom);
      check("digitSum", digitSum(rb), longint'($signed(rb)));
    end

    // Directed products.
    setReady(1);
    applyStimulus(8'd3, 8'd5, 1'b0);
    checkOutput("prod3x5", 15);
    check("lat3x5", longint'(lastLat), 4);
    applyStimulus(8'h80, 8'h80, 1'b0);
    checkOutput("prodMinMin", 16384);
    applyStimulus(8'h7F, 8'h80, 1'b0);
    checkOutput("prodMaxMin", -16256);
    applyStimulus(8'd7, 8'd119, 1'b0);
    checkOutput("prod7x119", 833);
    applyStimulus(8'd9, 8'd0, 1'b0);
    checkOutput("prodB0", 0);
`ifdef BOOTH16_EARLY_TERM_EN
    check("latB0", longint'(lastLat), 3);
`else
    check("latB0", longint'(lastLat), 4);
`endif
    applyStimulus(8'hEC, 8'd3, 1'b0);
    checkOutput("prodNeg20x3", -60);
    applyStimulus(8'd5, 8'hFF, 1'b0);
    checkOutput("prod5xM1", -5);

    // Consumer stalls for 5 cycles: product must hold, then retire in one edge.
    setReady(0);
    applyStimulus(8'd100, 8'hFD, 1'b0);
    t = 0;
    do begin
      @(negedge iClk);
      t++;
    end while (!oValid && t < 400);
    check("stallSeen", longint'(oValid), 1);
    repeat (5) begin
      @(negedge iClk);
      check("stallValid", longint'(oValid), 1);
      check("stallProd", longint'($signed(oProd)), -300);
    end
    setReady(1);
    @(posedge iClk);
    #1;
    check("postStallValid", longint'(oValid), 0);
    check("postStallReady", longint'(oReady), 1);

    // Abort in the middle of iterating, then a fresh pair must be clean.
    applyStimulus(8'd5, 8'd9, 1'b0);
    @(posedge iClk);
    #2;
    check("busyBeforeAbort", longint'(oBusy), 1);
    iRst_n = 1'b0;
    expQ.delete();
    inflight  = 1'b0;
    prevStall = 1'b0;
    seenValid = 1'b0;
    #1;
    check("abortValid", longint'(oValid), 0);
    check("abortBusy", longint'(oBusy), 0);
    check("abortProd", longint'(oProd), 0);
    @(posedge iClk);
    #1;
    iRst_n = 1'b1;
    check("abortReady", longint'(oReady), 1);
    applyStimulus(8'd2, 8'd3, 1'b0);
    checkOutput("prod2x3", 6);

    // Randomized traffic with consumer stalls, idle gaps and iValid held while busy.
    setReady(2);
    for (int n = 0; n < 1500; n++) begin
      applyStimulus(pickOperand(), pickOperand(), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge iClk);
          #1;
        end
      end
    end
    t = 0;
    while (inflight && t < 500) begin
      @(posedge iClk);
      #1;
      t++;
    end
    check("drained", longint'(inflight), 0);
    check("queueEmpty", longint'(expQ.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
